// File: rtl/scrambler_pkg.sv
// Shared constants and types for the 802.11a data scrambler (x^7 + x^4 + 1).
//   SEED_LEN     : number of SERVICE bits used to recover the descrambler state
//   TAP_A/TAP_B  : state bit positions XORed to form the feedback bit
//   DEFAULT_SEED : substitute for an all-zero programmed seed
//   RESET_STATE  : LFSR contents after reset and at descramble frame start
//   fsm_state_e  : frame-level control states
package scrambler_pkg;

  localparam int SEED_LEN = 7;
  localparam int TAP_A    = 6;
  localparam int TAP_B    = 3;

  localparam logic [SEED_LEN-1:0] DEFAULT_SEED = 7'b1011101;
  localparam logic [SEED_LEN-1:0] RESET_STATE  = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } fsm_state_e;

  // An all-zero LFSR never leaves zero, so a zero seed is replaced.
  function automatic logic [SEED_LEN-1:0] load_seed(input logic [SEED_LEN-1:0] seed);
    return (seed == '0) ? DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/scrambler_bit_step.sv
// One serial step of the scrambler LFSR, purely combinational.
// Chained W times by the top to process a whole beat per clock.
//   s_i          : LFSR state before this bit (bit 0 newest)
//   in_bit_i     : input bit
//   seed_phase_i : 1 = shift the received bit into the state, output 0
//   s_o          : LFSR state after this bit
//   out_bit_o    : scrambled / descrambled bit
module scrambler_bit_step
  import scrambler_pkg::*;
(
  input  logic [SEED_LEN-1:0] s_i,
  input  logic                in_bit_i,
  input  logic                seed_phase_i,
  output logic [SEED_LEN-1:0] s_o,
  output logic                out_bit_o
);

  logic fb;

  assign fb = s_i[TAP_A] ^ s_i[TAP_B];

  always_comb begin
    if (seed_phase_i) begin
      // During seed recovery the received bits are the scrambler sequence
      // itself (SERVICE bits are zero), so they become the state directly.
      s_o       = {s_i[SEED_LEN-2:0], in_bit_i};
      out_bit_o = 1'b0;
    end else begin
      s_o       = {s_i[SEED_LEN-2:0], fb};
      out_bit_o = in_bit_i ^ fb;
    end
  end

endmodule

// File: rtl/wlan_scrambler_par.sv
// 802.11a scrambler / descrambler processing W bits per clock.
// MODE=0 scrambles from a programmed seed; MODE=1 recovers the seed from the
// first 7 received bits of the frame, then descrambles the remainder.
//   clk_i       : rising-edge clock
//   rst_ni      : asynchronous active-low reset
//   start_i     : frame start, re-arms the block from any state
//   seed_i      : scramble seed, sampled on start_i (MODE=0)
//   in_valid_i  : qualifies in_data_i
//   in_data_i   : input bits, bit 0 earliest
//   out_valid_o : qualifies out_data_o (one cycle after the input beat)
//   out_data_o  : output bits, bit 0 earliest
//   locked_o    : LFSR state is valid for data
//   seed_o      : recovered (MODE=1) or loaded (MODE=0) seed
module wlan_scrambler_par
  import scrambler_pkg::*;
#(
  parameter int W    = 1,
  parameter bit MODE = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [SEED_LEN-1:0] seed_i,
  input  logic                in_valid_i,
  input  logic [W-1:0]        in_data_i,
  output logic                out_valid_o,
  output logic [W-1:0]        out_data_o,
  output logic                locked_o,
  output logic [SEED_LEN-1:0] seed_o
);

  fsm_state_e          state_q, state_d, eff_state;
  logic [SEED_LEN-1:0] s_q, s_d, eff_s;
  logic [2:0]          cnt_q, cnt_d, eff_cnt;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic                locked_q, locked_d;
  logic [SEED_LEN-1:0] seed_q, seed_d;

  logic [SEED_LEN-1:0] chain_s [W+1];
  logic [W-1:0]        chain_out;
  logic [W-1:0]        seed_ph;
  logic [SEED_LEN-1:0] seed_cap;
  logic                fire;
  logic                seed_done;

  // A Start in the same cycle as a beat means that beat already belongs to
  // the new frame, so the chain always runs from the post-Start view.
  always_comb begin
    eff_state = state_q;
    eff_cnt   = cnt_q;
    eff_s     = s_q;
    if (start_i) begin
      eff_cnt = '0;
      if (MODE) begin
        eff_state = SEED;
        eff_s     = RESET_STATE;
      end else begin
        eff_state = RUN;
        eff_s     = load_seed(seed_i);
      end
    end
  end

  assign chain_s[0] = eff_s;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_step
      // Bit gi is a seed bit while fewer than SEED_LEN bits precede it.
      assign seed_ph[gi] = (eff_state == SEED) && ((int'(eff_cnt) + gi) < SEED_LEN);

      scrambler_bit_step u_step (
        .s_i          (chain_s[gi]),
        .in_bit_i     (in_data_i[gi]),
        .seed_phase_i (seed_ph[gi]),
        .s_o          (chain_s[gi+1]),
        .out_bit_o    (chain_out[gi])
      );
    end
  endgenerate

  always_comb begin
    fire        = in_valid_i && (eff_state != IDLE);
    seed_done   = (eff_state == SEED) && ((int'(eff_cnt) + W) >= SEED_LEN);
    state_d     = eff_state;
    cnt_d       = eff_cnt;
    s_d         = eff_s;
    out_valid_d = fire;
    out_data_d  = '0;
    locked_d    = locked_q;
    seed_d      = seed_q;

    // State right after the 7th seed bit, wherever it falls in the beat.
    seed_cap = seed_q;
    for (int k = 0; k < W; k++) begin
      if ((int'(eff_cnt) + k + 1) == SEED_LEN) begin
        seed_cap = chain_s[k+1];
      end
    end

    if (start_i) begin
      locked_d = !MODE;
      if (!MODE) begin
        seed_d = eff_s;
      end
    end

    if (fire) begin
      s_d        = chain_s[W];
      out_data_d = chain_out;
      if (eff_state == SEED) begin
        if (seed_done) begin
          state_d  = RUN;
          cnt_d    = 3'(SEED_LEN);
          locked_d = 1'b1;
          seed_d   = seed_cap;
        end else begin
          // Only reached while eff_cnt + W < SEED_LEN, so 3 bits suffice.
          cnt_d = eff_cnt + 3'(W);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s_q         <= RESET_STATE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      locked_q    <= 1'b0;
      seed_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      locked_q    <= locked_d;
      seed_q      <= seed_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign locked_o    = locked_q;
  assign seed_o      = seed_q;

endmodule

// File: tb/tb_wlan_scrambler_par.sv
// Self-checking bench for wlan_scrambler_par. Four instances cover
// MODE=0/W=1, MODE=1/W=1, MODE=1/W=8 and MODE=0/W=5. Expected streams come
// from the recurrence p[n] = p[n-7] ^ p[n-4] over a bit history.
module tb_wlan_scrambler_par;

  localparam int WK [4] = '{1, 1, 8, 5};
  localparam bit MK [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start [4];
  logic        vld   [4];
  logic [15:0] din   [4];
  logic [6:0]  seed  [4];

  logic        ov   [4];
  logic [15:0] dout [4];
  logic        lk   [4];
  logic [6:0]  so   [4];

  wire       ov0, ov1, ov2, ov3, lk0, lk1, lk2, lk3;
  wire [0:0] od0, od1;
  wire [7:0] od2;
  wire [4:0] od3;
  wire [6:0] so0, so1, so2, so3;

  wlan_scrambler_par #(.W(1), .MODE(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .seed_i(seed[0]),
    .in_valid_i(vld[0]), .in_data_i(din[0][0:0]), .out_valid_o(ov0),
    .out_data_o(od0), .locked_o(lk0), .seed_o(so0));
  wlan_scrambler_par #(.W(1), .MODE(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .seed_i(seed[1]),
    .in_valid_i(vld[1]), .in_data_i(din[1][0:0]), .out_valid_o(ov1),
    .out_data_o(od1), .locked_o(lk1), .seed_o(so1));
  wlan_scrambler_par #(.W(8), .MODE(1'b1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .seed_i(seed[2]),
    .in_valid_i(vld[2]), .in_data_i(din[2][7:0]), .out_valid_o(ov2),
    .out_data_o(od2), .locked_o(lk2), .seed_o(so2));
  wlan_scrambler_par #(.W(5), .MODE(1'b0)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[3]), .seed_i(seed[3]),
    .in_valid_i(vld[3]), .in_data_i(din[3][4:0]), .out_valid_o(ov3),
    .out_data_o(od3), .locked_o(lk3), .seed_o(so3));

  assign ov[0] = ov0; assign ov[1] = ov1; assign ov[2] = ov2; assign ov[3] = ov3;
  assign lk[0] = lk0; assign lk[1] = lk1; assign lk[2] = lk2; assign lk[3] = lk3;
  assign so[0] = so0; assign so[1] = so1; assign so[2] = so2; assign so[3] = so3;
  assign dout[0] = {15'b0, od0};
  assign dout[1] = {15'b0, od1};
  assign dout[2] = {8'b0, od2};
  assign dout[3] = {11'b0, od3};

  int checks = 0;
  int errors = 0;

  bit        stim_q [$];
  bit        exp_q  [$];
  bit        pn_q   [$];
  logic [6:0] exp_seed;

  typedef struct {
    logic [6:0]  seed_in;
    logic [6:0]  exp_seed;
    logic [15:0] exp16;   // first 16 scrambler output bits, bit 0 first
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus on instance k; outputs for this beat are visible on return.
  task automatic cycle(input int k, input logic st, input logic v,
                       input logic [15:0] d, input logic [6:0] sd);
    start[k] = st;
    vld[k]   = v;
    din[k]   = d;
    seed[k]  = sd;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    vld[k]   = 1'b0;
  endtask

  // Reference: scramble = data ^ PN(seed); descramble = 7 zeros, then
  // data ^ PN continued from the first 7 received bits.
  function automatic void build_expect(input bit mode, input logic [6:0] sd);
    bit h [$];
    logic [6:0] s;
    bit p;
    exp_q.delete();
    if (!mode) s = (sd == 7'd0) ? 7'b1011101 : sd;
    else for (int i = 0; i < 7; i++) s[6-i] = stim_q[i];
    exp_seed = s;
    for (int i = 6; i >= 0; i--) h.push_back(s[i]);
    for (int n = 0; n < stim_q.size(); n++) begin
      if (mode && n < 7) begin
        exp_q.push_back(1'b0);
      end else begin
        p = h[h.size()-7] ^ h[h.size()-4];
        h.push_back(p);
        exp_q.push_back(stim_q[n] ^ p);
      end
    end
  endfunction

  task automatic run_stream(input int k, input logic [6:0] sd, input bit st_beat,
                            input bit gap, input int reset_at, input string tag);
    int w;
    bit mode;
    int nb;
    int consumed;
    logic [15:0] d, e;
    w    = WK[k];
    mode = MK[k];
    build_expect(mode, sd);
    nb = stim_q.size() / w;
    if (!st_beat) begin
      cycle(k, 1'b1, 1'b0, 16'h0, sd);
      chk({tag, " start locked"}, lk[k], !mode);
      chk({tag, " start valid"}, ov[k], 1'b0);
    end
    for (int b = 0; b < nb; b++) begin
      if (gap) begin
        repeat (2) begin
          cycle(k, 1'b0, 1'b0, 16'($urandom), sd);
          chk($sformatf("%s gap b%0d valid", tag, b), ov[k], 1'b0);
        end
      end
      if (b == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({tag, " rst valid"}, ov[k], 1'b0);
        chk({tag, " rst data"}, dout[k], 16'h0);
        chk({tag, " rst locked"}, lk[k], 1'b0);
        chk({tag, " rst seed"}, so[k], 7'h0);
        vld[k] = 1'b1;
        din[k] = 16'($urandom);
        @(posedge clk);
        #1;
        chk({tag, " in-rst valid"}, ov[k], 1'b0);
        #3 rst_n = 1'b1;
        repeat (3) begin
          @(posedge clk);
          #1;
          chk({tag, " post-rst no start"}, ov[k], 1'b0);
        end
        vld[k] = 1'b0;
        $display("frame %s inst=%0d reset at beat %0d", tag, k, b);
        return;
      end
      d = '0;
      e = '0;
      for (int j = 0; j < w; j++) begin
        d[j] = stim_q[b*w+j];
        e[j] = exp_q[b*w+j];
      end
      cycle(k, st_beat && (b == 0), 1'b1, d, sd);
      consumed = (b + 1) * w;
      chk($sformatf("%s b%0d valid", tag, b), ov[k], 1'b1);
      chk($sformatf("%s b%0d data", tag, b), dout[k], e);
      chk($sformatf("%s b%0d locked", tag, b), lk[k], mode ? (consumed >= 7) : 1'b1);
      if ((mode && consumed >= 7 && b*w < 7) || (!mode && b == 0))
        chk($sformatf("%s b%0d seed_out", tag, b), so[k], exp_seed);
    end
    $display("frame %s inst=%0d bits=%0d", tag, k, stim_q.size());
  endtask

  initial begin
    bit ob [128];
    bit tmp [$];
    logic [6:0] rs;

    tbl[0] = '{7'h7F, 7'h7F, 16'h4F70};
    tbl[1] = '{7'h00, 7'h5D, 16'h9836};
    tbl[2] = '{7'h5D, 7'h5D, 16'h9836};

    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0; vld[k] = 1'b0; din[k] = '0; seed[k] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset valid %0d", k), ov[k], 1'b0);
      chk($sformatf("reset data %0d", k), dout[k], 16'h0);
      chk($sformatf("reset locked %0d", k), lk[k], 1'b0);
      chk($sformatf("reset seed %0d", k), so[k], 7'h0);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(k, 1'b0, 1'b1, 16'hFFFF, 7'h0);
      chk($sformatf("idle drop %0d", k), ov[k], 1'b0);
    end

    // Table: known PN prefixes and period-127 wraparound (MODE=0, W=1)
    for (int t = 0; t < 3; t++) begin
      cycle(0, 1'b1, 1'b0, 16'h0, tbl[t].seed_in);
      chk($sformatf("tbl%0d locked", t), lk[0], 1'b1);
      for (int i = 0; i < 128; i++) begin
        cycle(0, 1'b0, 1'b1, 16'h0, tbl[t].seed_in);
        ob[i] = dout[0][0];
        if (i < 16) chk($sformatf("tbl%0d bit%0d", t, i), dout[0][0], tbl[t].exp16[i]);
      end
      chk($sformatf("tbl%0d seed_out", t), so[0], tbl[t].exp_seed);
      chk($sformatf("tbl%0d bit128==bit1", t), ob[127], ob[0]);
      $display("frame table%0d seed=%0h", t, tbl[t].seed_in);
    end

    // PN sequence from all-ones seed
    stim_q.delete();
    repeat (128) stim_q.push_back(1'b0);
    build_expect(1'b0, 7'h7F);
    pn_q = exp_q;

    stim_q.delete();
    for (int i = 0; i < 127; i++) stim_q.push_back(pn_q[i]);
    run_stream(1, 7'h0, 1'b0, 1'b0, -1, "pn_w1");

    stim_q = pn_q;
    run_stream(2, 7'h0, 1'b1, 1'b0, -1, "pn_w8");

    stim_q.delete();
    repeat (64) stim_q.push_back(1'($urandom_range(0, 1)));
    run_stream(0, 7'h00, 1'b0, 1'b0, -1, "seed_zero");

    // Abort at beat 40 with a fresh frame starting on the same beat
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back(pn_q[i]);
    run_stream(1, 7'h0, 1'b0, 1'b0, -1, "pre_abort");
    stim_q.delete();
    for (int i = 0; i < 127; i++) stim_q.push_back(pn_q[i]);
    run_stream(1, 7'h0, 1'b1, 1'b0, -1, "abort_restart");

    // Randomized frames
    for (int it = 0; it < 3; it++) begin
      rs = 7'($urandom);
      if (it == 1) rs = 7'h0;
      stim_q.delete();
      repeat (100) stim_q.push_back(1'($urandom_range(0, 1)));
      run_stream(3, rs, it == 1, it[0], -1, $sformatf("rand_scr%0d", it));

      rs = 7'($urandom_range(1, 127));
      stim_q.delete();
      repeat (7) stim_q.push_back(1'b0);
      repeat (113) stim_q.push_back(1'($urandom_range(0, 1)));
      build_expect(1'b0, rs);
      tmp = exp_q;
      stim_q = tmp;
      run_stream(2, 7'h0, it == 0, it[0], -1, $sformatf("rand_dscr%0d", it));
    end

    // Gapped input with reset in the middle, then a clean gapped frame
    stim_q.delete();
    for (int i = 0; i < 127; i++) stim_q.push_back(pn_q[i]);
    run_stream(1, 7'h0, 1'b0, 1'b1, 20, "gap_reset");
    run_stream(1, 7'h0, 1'b0, 1'b1, -1, "gap_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
